// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with an integrated busy scoreboard.
//   NUM_RD combinational read ports, two prioritised write ports (A over B),
//   one busy bit per register set by issue, cleared by writeback, or wiped
//   by flush. busy_cnt is a registered population count of the busy vector.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> same-cycle write data is forwarded to matching read ports
//                (port A preferred) and rd_busy is forced low on those ports.
//   undefined -> reads return stored contents only.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   rd_addr / rd_data   packed per-port read address / read data
//   rd_busy             per-port busy flag of the addressed register
//   wa_* / wb_*         write ports A (higher priority) and B
//   iss_en / iss_addr   mark a register as having an in-flight producer
//   flush               synchronous clear of all busy bits
//   busy_cnt            number of registers currently busy
module regfile_mp_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wa_en,
  input  logic [ADDR_W-1:0]          wa_addr,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       flush,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  busy_cnt_q;
  logic [CNT_W-1:0]  busy_cnt_d;

  // Register write: port A wins over port B on an address collision.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!((ZERO_REG != 0) && (i == 0))) begin
        if (wa_en && (wa_addr == ADDR_W'(i))) begin
          regs_d[i] = wa_data;
        end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
          regs_d[i] = wb_data;
        end
      end
    end
  end

  // Busy update: write clears, then issue sets (new producer supersedes),
  // then flush overrides everything.
  always_comb begin
    busy_d = busy_q;
    if (wa_en) busy_d[wa_addr] = 1'b0;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (iss_en) busy_d[iss_addr] = 1'b1;
    if (flush) busy_d = '0;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Population count of the post-edge busy vector.
  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Read ports.
  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_c;
    logic              busy_c;
    logic              zero_hit;

    assign addr     = rd_addr[k*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);

    always_comb begin
      data_c = regs_q[addr];
      busy_c = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (wa_en && (wa_addr == addr)) begin
        data_c = wa_data;
        busy_c = 1'b0;
      end else if (wb_en && (wb_addr == addr)) begin
        data_c = wb_data;
        busy_c = 1'b0;
      end
`endif
      // Hard-wired zero register and reset both force a quiet output.
      if (zero_hit || reset) begin
        data_c = '0;
        busy_c = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_c;
    assign rd_busy[k]                  = busy_c;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (default parameters).
module tb_regfile_mp_sb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;

  logic                     clk;
  logic                     reset;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wa_en, wb_en, iss_en, flush;
  logic [ADDR_W-1:0]        wa_addr, wb_addr, iss_addr;
  logic [DATA_W-1:0]        wa_data, wb_data;
  logic [ADDR_W:0]          busy_cnt;

  int checks;
  int failures;

  regfile_mp_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rdd(input int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
    rd_addr[k*ADDR_W +: ADDR_W] = a;
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    rd_addr = '0;
    wa_addr = '0; wb_addr = '0; iss_addr = '0;
    wa_data = '0; wb_data = '0;
    idle();

    // Reset state.
    #2;
    set_rd(0, 5'd4); set_rd(1, 5'd9);
    #1;
    check("reset_rd0", rdd(0), 0);
    check("reset_busy", 64'(rd_busy), 0);
    check("reset_cnt", 64'(busy_cnt), 0);
    #9 reset = 1'b0;   // t=12, between edges

    // Read every register after reset.
    for (int i = 0; i < 32; i++) begin
      set_rd(0, 5'(i));
      #1;
      check($sformatf("init_r%0d", i), rdd(0), 0);
    end

    // Write r5, then asynchronous reset clears it immediately.
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h1234;
    tick(); idle();
    set_rd(0, 5'd5);
    #1;
    check("r5_written", rdd(0), 32'h1234);
    #1 reset = 1'b1;
    #1;
    check("r5_async_reset", rdd(0), 0);
    #1 reset = 1'b0;
    #1;
    check("r5_after_reset", rdd(0), 0);

    // Same-address dual write: A wins.
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hAAAA0000;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h5555FFFF;
    tick(); idle();
    set_rd(1, 5'd3);
    #1;
    check("dual_write_r3", rdd(1), 32'hAAAA0000);

    // Writes to r0 are dropped.
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1111_1111;
    tick(); idle();
    set_rd(0, 5'd0);
    #1;
    check("r0_zero", rdd(0), 0);

    // Issue r7, busy for 3 cycles, then wb r7 clears it.
    iss_en = 1'b1; iss_addr = 5'd7;
    tick(); idle();
    set_rd(0, 5'd7);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("r7_busy_c%0d", c), 64'(rd_busy[0]), 1);
      check($sformatf("r7_cnt_c%0d", c), 64'(busy_cnt), 1);
      if (c < 2) tick();
    end
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r7_wr_cycle_busy", 64'(rd_busy[0]), 0);
    check("r7_wr_cycle_data", rdd(0), 32'h77);
`else
    check("r7_wr_cycle_busy", 64'(rd_busy[0]), 1);
    check("r7_wr_cycle_data", rdd(0), 0);
`endif
    tick(); idle();
    #1;
    check("r7_busy_clr", 64'(rd_busy[0]), 0);
    check("r7_cnt_clr", 64'(busy_cnt), 0);
    check("r7_data", rdd(0), 32'h77);

    // Issue and write the same register in one cycle: set wins.
    iss_en = 1'b1; iss_addr = 5'd9;
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h99;
    tick(); idle();
    set_rd(1, 5'd9);
    #1;
    check("r9_data", rdd(1), 32'h99);
    check("r9_busy", 64'(rd_busy[1]), 1);
    check("r9_cnt", 64'(busy_cnt), 1);

    // Issue r1, r2, r4; re-issue r1; issue r0 (ignored).
    iss_en = 1'b1;
    iss_addr = 5'd1; tick();
    iss_addr = 5'd2; tick();
    iss_addr = 5'd4; tick();
    check("cnt_after_124", 64'(busy_cnt), 4);
    iss_addr = 5'd1; tick();
    check("cnt_reissue_r1", 64'(busy_cnt), 4);
    iss_addr = 5'd0; tick();
    idle();
    set_rd(0, 5'd0);
    #1;
    check("cnt_iss_r0", 64'(busy_cnt), 4);
    check("r0_not_busy", 64'(rd_busy[0]), 0);

    // Flush beats a same-cycle issue.
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
    tick(); idle();
    set_rd(0, 5'd6); set_rd(1, 5'd9);
    #1;
    check("flush_cnt", 64'(busy_cnt), 0);
    check("flush_busy", 64'(rd_busy), 0);

    // Bypass: r8 holds 0x1111, then wa r8=0xDEAD with read of r8.
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h1111;
    tick(); idle();
    wa_en = 1'b1; wa_addr = 5'd8; wa_data = 32'hDEAD;
    set_rd(0, 5'd8);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r8_bypass", rdd(0), 32'hDEAD);
`else
    check("r8_bypass", rdd(0), 32'h1111);
`endif
    tick(); idle();
    #1;
    check("r8_next", rdd(0), 32'hDEAD);

    // Bypass priority A over B on a read port.
    wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'hA;
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hB;
    set_rd(1, 5'd10);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r10_bypass_prio", rdd(1), 32'hA);
`else
    check("r10_bypass_prio", rdd(1), 0);
`endif
    tick(); idle();
    #1;
    check("r10_stored", rdd(1), 32'hA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
